// File: rtl/wb_register_file_pkg.sv
// rtl/wb_register_file_pkg.sv - shared constants for the write-back register file
package wb_register_file_pkg;
   localparam int REG_ADDR_W = 5;
   localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

   localparam logic WB_SRC_ALU = 1'b0;
   localparam logic WB_SRC_MEM = 1'b1;
endpackage

// File: rtl/wb_register_file_wb_select.sv
// rtl/wb_register_file_wb_select.sv - MemtoReg write-back data multiplexer
module wb_select
   import wb_register_file_pkg::*;
#(
   parameter int B = 32
) (
   input  logic         mem_to_reg,
   input  logic [B-1:0] read_data,
   input  logic [B-1:0] alu_result,
   output logic [B-1:0] wb_data
);
   always_comb begin
      wb_data = alu_result;
      if (mem_to_reg == WB_SRC_MEM) begin
         wb_data = read_data;
      end
   end
endmodule

// File: rtl/wb_register_file.sv
// rtl/wb_register_file.sv - MEM/WB write-back stage with 2-read/1-write bypassed register bank
// Optional WB_DEBUG_PORT_EN adds an unbypassed debug read port (dbg_addr/dbg_data).
module wb_register_file
   import wb_register_file_pkg::*;
#(
   parameter int B      = 32,
   parameter int N_REGS = 32,
   parameter int CNT_W  = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [B-1:0]          read_data_in,
   input  logic [B-1:0]          alu_result_in,
   input  logic [B-1:0]          mux_RegDst_in,
   input  logic                  wb_RegWrite_in,
   input  logic                  wb_MemtoReg_in,
   input  logic [REG_ADDR_W-1:0] rs_addr,
   input  logic [REG_ADDR_W-1:0] rt_addr,
   output logic [B-1:0]          rs_data,
   output logic [B-1:0]          rt_data,
   output logic [B-1:0]          wb_data_out,
`ifdef WB_DEBUG_PORT_EN
   input  logic [REG_ADDR_W-1:0] dbg_addr,
   output logic [B-1:0]          dbg_data,
`endif
   output logic [CNT_W-1:0]      wb_count
);
   logic [B-1:0]          regs_q [N_REGS];
   logic [B-1:0]          regs_d [N_REGS];
   logic [CNT_W-1:0]      cnt_q;
   logic [CNT_W-1:0]      cnt_d;
   logic [REG_ADDR_W-1:0] waddr;
   logic                  commit;
   logic                  unused_dst_bits;

   wb_select #(.B(B)) u_wb_select (
      .mem_to_reg (wb_MemtoReg_in),
      .read_data  (read_data_in),
      .alu_result (alu_result_in),
      .wb_data    (wb_data_out)
   );

   // Only the low address bits name a register; the rest of the field is don't-care.
   assign waddr           = mux_RegDst_in[REG_ADDR_W-1:0];
   assign unused_dst_bits = ^mux_RegDst_in[B-1:REG_ADDR_W];
   assign commit          = wb_RegWrite_in && (waddr != REG_ZERO) && !reset;

   always_comb begin
      regs_d = regs_q;
      cnt_d  = cnt_q;
      if (commit) begin
         regs_d[waddr] = wb_data_out;
         cnt_d         = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < N_REGS; i++) begin
            regs_q[i] <= '0;
         end
         cnt_q <= '0;
      end else begin
         regs_q <= regs_d;
         cnt_q  <= cnt_d;
      end
   end

   always_comb begin
      rs_data = regs_q[rs_addr];
      if (rs_addr == REG_ZERO) begin
         rs_data = '0;
      end else if (commit && (rs_addr == waddr)) begin
         rs_data = wb_data_out;
      end
   end

   always_comb begin
      rt_data = regs_q[rt_addr];
      if (rt_addr == REG_ZERO) begin
         rt_data = '0;
      end else if (commit && (rt_addr == waddr)) begin
         rt_data = wb_data_out;
      end
   end

`ifdef WB_DEBUG_PORT_EN
   assign dbg_data = (dbg_addr == REG_ZERO) ? '0 : regs_q[dbg_addr];
`endif

   assign wb_count = cnt_q;
endmodule

// File: tb/tb_wb_register_file.sv
// tb/tb_wb_register_file.sv - self-checking bench for wb_register_file against a register-array model
module tb_wb_register_file;
   logic        clk;
   logic        reset;
   logic [31:0] read_data_in;
   logic [31:0] alu_result_in;
   logic [31:0] mux_RegDst_in;
   logic        wb_RegWrite_in;
   logic        wb_MemtoReg_in;
   logic [4:0]  rs_addr;
   logic [4:0]  rt_addr;
   logic [31:0] rs_data;
   logic [31:0] rt_data;
   logic [31:0] wb_data_out;
   logic [3:0]  wb_count;

   int          n_vec;
   int          n_bad;
   logic [31:0] ref_regs [32];
   int          ref_cnt;

   wb_register_file #(.B(32), .N_REGS(32), .CNT_W(4)) dut (
      .clk            (clk),
      .reset          (reset),
      .read_data_in   (read_data_in),
      .alu_result_in  (alu_result_in),
      .mux_RegDst_in  (mux_RegDst_in),
      .wb_RegWrite_in (wb_RegWrite_in),
      .wb_MemtoReg_in (wb_MemtoReg_in),
      .rs_addr        (rs_addr),
      .rt_addr        (rt_addr),
      .rs_data        (rs_data),
      .rt_data        (rt_data),
      .wb_data_out    (wb_data_out),
      .wb_count       (wb_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic rst, input logic we, input logic m2r, input logic [31:0] rd,
                        input logic [31:0] alu, input logic [31:0] dst,
                        input logic [4:0] ra, input logic [4:0] rb);
      reset          = rst;
      wb_RegWrite_in = we;
      wb_MemtoReg_in = m2r;
      read_data_in   = rd;
      alu_result_in  = alu;
      mux_RegDst_in  = dst;
      rs_addr        = ra;
      rt_addr        = rb;
   endtask

   // Expected read value from the architectural rules: r0 is zero, a live write bypasses.
   function automatic logic [31:0] exp_read(input logic [4:0] a, input logic [31:0] wbd);
      if (a == 5'd0) return 32'h0;
      if (!reset && wb_RegWrite_in && mux_RegDst_in[4:0] != 5'd0 && a == mux_RegDst_in[4:0])
         return wbd;
      return ref_regs[a];
   endfunction

   // Inputs are already driven; check at negedge, then advance the model at posedge.
   task automatic cycle(input bit check_reads);
      logic [31:0] wbd;
      @(negedge clk);
      wbd = wb_MemtoReg_in ? read_data_in : alu_result_in;
      chk("wb_data_out", wb_data_out, wbd);
      if (check_reads) begin
         chk("rs_data", rs_data, exp_read(rs_addr, wbd));
         chk("rt_data", rt_data, exp_read(rt_addr, wbd));
         chk("wb_count", {28'h0, wb_count}, 32'(ref_cnt));
      end
      @(posedge clk);
      if (reset) begin
         for (int i = 0; i < 32; i++) ref_regs[i] = 32'h0;
         ref_cnt = 0;
      end else if (wb_RegWrite_in && mux_RegDst_in[4:0] != 5'd0) begin
         ref_regs[mux_RegDst_in[4:0]] = wbd;
         ref_cnt = (ref_cnt + 1) % 16;
      end
      #1;
   endtask

   initial begin
      n_vec   = 0;
      n_bad   = 0;
      ref_cnt = 0;
      for (int i = 0; i < 32; i++) ref_regs[i] = 32'h0;
      drive(1'b1, 1'b1, 1'b0, 32'h0, 32'hAAAA_AAAA, 32'd9, 5'd9, 5'd9);
      @(posedge clk);
      #1;
      cycle(1'b0);

      // Reset state: every address reads zero on both ports.
      for (int a = 0; a < 32; a++) begin
         drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 5'(a), 5'(31 - a));
         cycle(1'b1);
      end

      // ALU write-back, then read from the array.
      drive(1'b0, 1'b1, 1'b0, 32'h0, 32'h0000_1234, 32'd5, 5'd0, 5'd0);
      cycle(1'b1);
      drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 5'd5, 5'd5);
      cycle(1'b1);
      chk("count_after_alu_wb", {28'h0, wb_count}, 32'd1);

      // Load write-back with same-cycle bypass on both ports.
      drive(1'b0, 1'b1, 1'b1, 32'hDEAD_BEEF, 32'h1111_1111, 32'd7, 5'd7, 5'd7);
      cycle(1'b1);
      drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 5'd7, 5'd7);
      cycle(1'b1);
      chk("rs_reg7_direct", rs_data, 32'hDEAD_BEEF);

      // Register 0 write is dropped and not counted.
      drive(1'b0, 1'b1, 1'b0, 32'h0, 32'hFFFF_FFFF, 32'd0, 5'd0, 5'd0);
      cycle(1'b1);
      drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd7);
      cycle(1'b1);
      chk("count_after_r0_write", {28'h0, wb_count}, 32'd2);

      // Upper destination bits ignored; reset discards the write it coincides with.
      drive(1'b0, 1'b1, 1'b0, 32'h0, 32'h0000_0055, 32'h0000_0023, 5'd3, 5'd0);
      cycle(1'b1);
      drive(1'b1, 1'b1, 1'b0, 32'h0, 32'h0000_0066, 32'd3, 5'd3, 5'd3);
      cycle(1'b1);
      drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 5'd3, 5'd7);
      cycle(1'b1);
      chk("reg3_after_reset", rs_data, 32'h0);

      // Randomized traffic with occasional resets.
      for (int n = 0; n < 300; n++) begin
         drive(($urandom_range(0, 31) == 0), ($urandom_range(0, 3) != 0), 1'($urandom),
               $urandom, $urandom, ($urandom_range(0, 1) != 0) ? 32'($urandom_range(0, 7)) : $urandom,
               ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 7)) : 5'($urandom),
               ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 7)) : 5'($urandom));
         cycle(1'b1);
      end

      // Counter wrap: 17 commits from zero leaves a 4-bit count at 1.
      drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0);
      cycle(1'b1);
      for (int n = 0; n < 17; n++) begin
         drive(1'b0, 1'b1, 1'b0, 32'h0, 32'(n + 100), 32'd1, 5'd1, 5'd2);
         cycle(1'b1);
      end
      drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 5'd1, 5'd1);
      cycle(1'b1);
      chk("count_wrap", {28'h0, wb_count}, 32'd1);
      chk("reg1_last", rs_data, 32'd116);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
